adder_sum_collector: RTL and testbench
======================================

Name: adder_sum_collector

Overview:
- Downstream consumer of the registered adder benchmark stage.
- Samples the adder's `sum` output, qualified by an externally supplied valid.
- Accumulates blocks of ACC_COUNT sums into a wider total and hands completed totals to a downstream sink over a valid/ready handshake.
- The adder cannot be stalled, so the block buffers completed totals and counts any it must drop.

Parameters:
- SUM_WIDTH, 30, width of the incoming adder sum (adder width 29 + carry).
- ACC_COUNT, 8, number of sums per block; power of two, >= 2.
- CNT_WIDTH, 4, width of the count field; clog2(ACC_COUNT)+1.
- ACC_WIDTH, 33, accumulator width; SUM_WIDTH + clog2(ACC_COUNT), overflow-free.
- DROP_WIDTH, 8, width of the dropped-block counter.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  in_sum is a valid adder result this cycle.
- in_sum  input  SUM_WIDTH  adder sum.
- flush  input  1  close the current partial block early.
- out_valid  output  1  out_acc/out_count hold a completed block.
- out_ready  input  1  sink accepts the block when out_valid & out_ready.
- out_acc  output  ACC_WIDTH  block total.
- out_count  output  CNT_WIDTH  number of sums in the block, 1..ACC_COUNT.
- overflow  output  1  sticky: at least one block was dropped.
- drop_count  output  DROP_WIDTH  dropped blocks, saturating at all-ones.

Behaviour:
- Reset (synchronous, active-high): acc=0, cnt=0, FIFO empty, out_valid=0, out_acc=0, out_count=0, overflow=0, drop_count=0. Reset overrides all other inputs in the same cycle, including mid-block; any partial sum is discarded.
- Accumulator FSM states:
  - EMPTY: cnt==0.
  - ACCUM: 0<cnt<ACC_COUNT.
- Each cycle, `next = acc + (in_valid ? zero-extended in_sum : 0)` and `ncnt = cnt + in_valid`.
- Block completes when either condition holds:
  - ncnt==ACC_COUNT; or
  - flush==1 and ncnt>0.
  - On completion: push {next, ncnt} into the output FIFO, then acc=0, cnt=0 (state EMPTY).
- Otherwise acc=next, cnt=ncnt. State is EMPTY if ncnt==0, ACCUM otherwise.
- Flush with ncnt==0 is a no-op.
- Flush in the same cycle as in_valid includes that sum in the flushed block.
- Output FIFO:
  - 2 entries, first-word fall-through, registered outputs.
  - out_valid = FIFO not empty; out_acc/out_count come from the head entry.
  - Latency: completion at edge t gives out_valid=1 after edge t (visible in cycle t+1).
  - Pop on out_valid & out_ready.
  - Push is accepted if FIFO not full, or if full and popping in the same cycle (pop frees the slot first).
  - If full and not popping, the completed block is dropped: overflow<=1, drop_count increments (saturating), accumulator still restarts.
  - out_acc/out_count hold their value while out_valid & !out_ready.
  - When empty, out_acc/out_count hold the last popped values (0 after reset).
- Arithmetic: unsigned, zero-extension only. ACC_WIDTH guarantees no wrap: max total ACC_COUNT*(2^SUM_WIDTH-1).
- Counters: cnt wraps only through completion, never arithmetically. drop_count stops at 2^DROP_WIDTH-1.

Decomposition:
- Package `adder_collector_pkg`:
  - functions clog2 and acc_width;
  - FSM state encoding (EMPTY/ACCUM);
  - the FIFO entry struct {acc, count}.
- One sub-module: `collector_fifo2`, a 2-entry FWFT FIFO with push/pop/full/empty and simultaneous push-while-full-and-pop support.
- Accumulator, FSM and drop logic stay in the top module.

Test Plan:
- Reset, then 8 consecutive in_valid with in_sum=1, out_ready=1 -> one cycle after the 8th sample: out_valid=1, out_acc=8, out_count=8; next cycle out_valid=0.
- 8 sums of 0x3FFFFFFF -> out_acc=0x1FFFFFFF8 (no wrap), out_count=8.
- 3 sums {5,6,7} then flush=1 with in_valid=1, in_sum=10 -> out_acc=28, out_count=4. A further flush with no valid -> no new output.
- out_ready=0, 24 valid sums of 1 -> first two blocks are held (out_acc=8 stable); third block dropped: overflow=1, drop_count=1. Then out_ready=1 -> exactly two blocks popped.
- FIFO full, with out_ready=1 in the same cycle a block completes -> no drop, drop_count unchanged, pop order preserved.
- reset asserted after 5 of 8 sums -> all outputs 0. Then 8 new sums of 2 -> out_acc=16 (stale partial sum gone).

Source files
------------

// File: rtl/adder_collector_pkg.sv
// Shared definitions for the adder sum collector: width helpers, the
// accumulator state encoding and the default output FIFO entry layout.
package adder_collector_pkg;

    // Ceiling log2 for positive values; clog2(1) = 0.
    function automatic int clog2(input int value);
        int res;
        res = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 <<< i) < value) begin
                res = i + 1;
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    // Accumulator width that can hold count full-scale sums without wrapping.
    function automatic int acc_width(input int sum_width, input int count);
        return sum_width + clog2(count);
    endfunction

    localparam int SUM_WIDTH_DEF  = 30;
    localparam int ACC_COUNT_DEF  = 8;
    localparam int CNT_WIDTH_DEF  = clog2(ACC_COUNT_DEF) + 1;
    localparam int ACC_WIDTH_DEF  = acc_width(SUM_WIDTH_DEF, ACC_COUNT_DEF);
    localparam int DROP_WIDTH_DEF = 8;

    // EMPTY: no sums collected yet; ACCUM: a partial block is in progress.
    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_ACCUM = 1'b1
    } acc_state_e;

    // Completed block as stored in the output FIFO.
    typedef struct packed {
        logic [ACC_WIDTH_DEF-1:0] acc;
        logic [CNT_WIDTH_DEF-1:0] count;
    } collector_entry_t;

endpackage

// File: rtl/collector_fifo2.sv
// Two-entry first-word-fall-through FIFO. The head entry is a register, so
// the consumer sees registered data. A push while full is legal only when a
// pop happens in the same cycle; the pop frees the slot first. When the FIFO
// drains, the head register keeps the last popped entry.
module collector_fifo2
    import adder_collector_pkg::*;
#(
    parameter type entry_t = collector_entry_t
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   push,
    input  entry_t push_data,
    input  logic   pop,
    output entry_t head,
    output logic   full,
    output logic   empty
);

    entry_t      slot0_r;
    entry_t      slot1_r;
    logic [1:0]  count_r;
    logic        pop_s;
    logic        push_s;

    assign empty = (count_r == 2'd0);
    assign full  = (count_r == 2'd2);
    assign head  = slot0_r;

    // Qualify requests: no pop from empty, no push into a full FIFO unless popping.
    always_comb begin
        pop_s  = pop & ~empty;
        push_s = push & (~full | pop_s);
    end

    // Storage and occupancy update.
    always_ff @(posedge clk) begin
        if (reset) begin
            slot0_r <= '0;
            slot1_r <= '0;
            count_r <= 2'd0;
        end else begin
            case ({push_s, pop_s})
                2'b10: begin
                    if (count_r == 2'd0) begin
                        slot0_r <= push_data;
                    end else begin
                        slot1_r <= push_data;
                    end
                    count_r <= count_r + 2'd1;
                end
                2'b01: begin
                    if (count_r == 2'd2) begin
                        slot0_r <= slot1_r;
                    end else begin
                        slot0_r <= slot0_r;
                    end
                    count_r <= count_r - 2'd1;
                end
                2'b11: begin
                    if (count_r == 2'd2) begin
                        slot0_r <= slot1_r;
                        slot1_r <= push_data;
                    end else begin
                        slot0_r <= push_data;
                    end
                end
                default: begin
                    count_r <= count_r;
                end
            endcase
        end
    end

endmodule

// File: rtl/adder_sum_collector.sv
// Collects blocks of ACC_COUNT adder sums into a wide total and offers each
// completed block downstream through a 2-entry FIFO. The adder cannot be
// stalled, so a block that finds the FIFO full is dropped and counted.
module adder_sum_collector
    import adder_collector_pkg::*;
#(
    parameter int SUM_WIDTH  = 30,
    parameter int ACC_COUNT  = 8,
    parameter int CNT_WIDTH  = clog2(ACC_COUNT) + 1,
    parameter int ACC_WIDTH  = acc_width(SUM_WIDTH, ACC_COUNT),
    parameter int DROP_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic [SUM_WIDTH-1:0]  in_sum,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ACC_WIDTH-1:0]  out_acc,
    output logic [CNT_WIDTH-1:0]  out_count,
    output logic                  overflow,
    output logic [DROP_WIDTH-1:0] drop_count
);

    typedef struct packed {
        logic [ACC_WIDTH-1:0] acc;
        logic [CNT_WIDTH-1:0] count;
    } entry_t;

    localparam logic [CNT_WIDTH-1:0] FULL_CNT = CNT_WIDTH'(ACC_COUNT);

    acc_state_e            state_r;
    acc_state_e            state_next_s;
    logic [ACC_WIDTH-1:0]  acc_r;
    logic [CNT_WIDTH-1:0]  cnt_r;
    logic [ACC_WIDTH-1:0]  acc_next_s;
    logic [CNT_WIDTH-1:0]  cnt_next_s;
    logic [ACC_WIDTH-1:0]  sum_ext_s;
    logic [ACC_WIDTH-1:0]  next_acc_s;
    logic [CNT_WIDTH-1:0]  ncnt_s;
    logic                  complete_s;
    logic                  pop_s;
    logic                  push_s;
    logic                  drop_s;
    logic                  fifo_full_s;
    logic                  fifo_empty_s;
    entry_t                push_data_s;
    entry_t                head_s;
    logic                  overflow_r;
    logic [DROP_WIDTH-1:0] drop_count_r;

    // Running total including this cycle's sample, and the block-close decision.
    always_comb begin
        sum_ext_s   = in_valid ? {{(ACC_WIDTH-SUM_WIDTH){1'b0}}, in_sum} : {ACC_WIDTH{1'b0}};
        next_acc_s  = acc_r + sum_ext_s;
        ncnt_s      = cnt_r + {{(CNT_WIDTH-1){1'b0}}, in_valid};
        complete_s  = (ncnt_s == FULL_CNT) | (flush & (ncnt_s != {CNT_WIDTH{1'b0}}));
        pop_s       = ~fifo_empty_s & out_ready;
        push_s      = complete_s & (~fifo_full_s | pop_s);
        drop_s      = complete_s & fifo_full_s & ~pop_s;
        push_data_s = '{acc: next_acc_s, count: ncnt_s};
    end

    // Accumulator FSM: next state and next accumulator contents.
    always_comb begin
        state_next_s = ST_EMPTY;
        acc_next_s   = next_acc_s;
        cnt_next_s   = ncnt_s;
        case (state_r)
            ST_EMPTY: begin
                if (complete_s) begin
                    state_next_s = ST_EMPTY;
                end else if (in_valid) begin
                    state_next_s = ST_ACCUM;
                end else begin
                    state_next_s = ST_EMPTY;
                end
            end
            ST_ACCUM: begin
                if (complete_s) begin
                    state_next_s = ST_EMPTY;
                end else begin
                    state_next_s = ST_ACCUM;
                end
            end
            default: begin
                state_next_s = ST_EMPTY;
            end
        endcase
        if (complete_s) begin
            acc_next_s = {ACC_WIDTH{1'b0}};
            cnt_next_s = {CNT_WIDTH{1'b0}};
        end else begin
            acc_next_s = next_acc_s;
            cnt_next_s = ncnt_s;
        end
    end

    // Accumulator and state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_EMPTY;
            acc_r   <= {ACC_WIDTH{1'b0}};
            cnt_r   <= {CNT_WIDTH{1'b0}};
        end else begin
            state_r <= state_next_s;
            acc_r   <= acc_next_s;
            cnt_r   <= cnt_next_s;
        end
    end

    // Sticky overflow flag and saturating count of dropped blocks.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow_r   <= 1'b0;
            drop_count_r <= {DROP_WIDTH{1'b0}};
        end else if (drop_s) begin
            overflow_r <= 1'b1;
            if (drop_count_r != {DROP_WIDTH{1'b1}}) begin
                drop_count_r <= drop_count_r + DROP_WIDTH'(1);
            end else begin
                drop_count_r <= drop_count_r;
            end
        end else begin
            overflow_r   <= overflow_r;
            drop_count_r <= drop_count_r;
        end
    end

    collector_fifo2 #(
        .entry_t (entry_t)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push_s),
        .push_data (push_data_s),
        .pop       (pop_s),
        .head      (head_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s)
    );

    assign out_valid  = ~fifo_empty_s;
    assign out_acc    = head_s.acc;
    assign out_count  = head_s.count;
    assign overflow   = overflow_r;
    assign drop_count = drop_count_r;

endmodule

// File: tb/tb_adder_sum_collector.sv
// Self-checking bench for adder_sum_collector: directed scenarios plus a
// randomized run compared against a queue-based model of block collection.
module tb_adder_sum_collector;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic [29:0] in_sum;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [32:0] out_acc;
    logic [3:0]  out_count;
    logic        overflow;
    logic [7:0]  drop_count;

    int n_checks;
    int n_fail;

    // Reference model state
    longint m_acc;
    int     m_cnt;
    longint mq_acc[$];
    int     mq_cnt[$];
    longint m_last_acc;
    int     m_last_cnt;
    bit     m_ovf;
    int     m_drop;

    logic        e_valid;
    logic [32:0] e_acc;
    logic [3:0]  e_count;
    logic        e_ovf;
    logic [7:0]  e_drop;

    adder_sum_collector dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_sum     (in_sum),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_acc    (out_acc),
        .out_count  (out_count),
        .overflow   (overflow),
        .drop_count (drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: sink pops first, then the sample is added, then a finished block
    // goes to the queue if it has room, otherwise it is dropped.
    task automatic model_cycle(input logic v, input logic [29:0] s, input logic f,
                               input logic r, input logic rst);
        if (rst) begin
            m_acc = 0; m_cnt = 0; mq_acc.delete(); mq_cnt.delete();
            m_last_acc = 0; m_last_cnt = 0; m_ovf = 0; m_drop = 0;
        end else begin
            if (r && mq_acc.size() > 0) begin
                m_last_acc = mq_acc.pop_front();
                m_last_cnt = mq_cnt.pop_front();
            end
            if (v) begin
                m_acc = m_acc + longint'(s);
                m_cnt = m_cnt + 1;
            end
            if (m_cnt == 8 || (f && m_cnt > 0)) begin
                if (mq_acc.size() < 2) begin
                    mq_acc.push_back(m_acc);
                    mq_cnt.push_back(m_cnt);
                end else begin
                    m_ovf = 1;
                    if (m_drop < 255) m_drop = m_drop + 1;
                end
                m_acc = 0;
                m_cnt = 0;
            end
        end
        e_valid = (mq_acc.size() > 0);
        e_acc   = e_valid ? 33'(mq_acc[0]) : 33'(m_last_acc);
        e_count = e_valid ? 4'(mq_cnt[0]) : 4'(m_last_cnt);
        e_ovf   = m_ovf;
        e_drop  = 8'(m_drop);
    endtask

    // Drive one cycle of inputs at the falling edge, advance the model on the
    // rising edge, and leave time 1 unit past the edge for sampling.
    task automatic step(input logic v, input logic [29:0] s, input logic f,
                        input logic r, input logic rst);
        @(negedge clk);
        in_valid = v; in_sum = s; flush = f; out_ready = r; reset = rst;
        @(posedge clk);
        model_cycle(v, s, f, r, rst);
        #1;
    endtask

    task automatic test_reset();
        step(1'b1, 30'd9, 1'b0, 1'b0, 1'b1);
        step(1'b0, 30'd0, 1'b0, 1'b0, 1'b1);
        n_checks++;
        if (out_valid !== 1'b0 || out_acc !== 33'd0 || out_count !== 4'd0 ||
            overflow !== 1'b0 || drop_count !== 8'd0) begin
            n_fail++;
            $display("FAIL reset: valid=%b acc=%0d cnt=%0d ovf=%b drop=%0d, required all zero",
                     out_valid, out_acc, out_count, overflow, drop_count);
        end
    endtask

    task automatic test_basic();
        step(1'b0, 30'd0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 8; i++) step(1'b1, 30'd1, 1'b0, 1'b1, 1'b0);
        n_checks++;
        if (out_valid !== 1'b1 || out_acc !== 33'd8 || out_count !== 4'd8) begin
            n_fail++;
            $display("FAIL basic_block: valid=%b acc=%0d cnt=%0d, required 1/8/8",
                     out_valid, out_acc, out_count);
        end
        step(1'b0, 30'd0, 1'b0, 1'b1, 1'b0);
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_pop: valid=%b, required 0", out_valid);
        end
    endtask

    task automatic test_max_no_wrap();
        for (int i = 0; i < 8; i++) step(1'b1, 30'h3FFFFFFF, 1'b0, 1'b1, 1'b0);
        n_checks++;
        if (out_valid !== 1'b1 || out_acc !== 33'h1FFFFFFF8 || out_count !== 4'd8) begin
            n_fail++;
            $display("FAIL max_sum: valid=%b acc=%h cnt=%0d, required 1/1fffffff8/8",
                     out_valid, out_acc, out_count);
        end
        step(1'b0, 30'd0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_flush();
        step(1'b1, 30'd5, 1'b0, 1'b1, 1'b0);
        step(1'b1, 30'd6, 1'b0, 1'b1, 1'b0);
        step(1'b1, 30'd7, 1'b0, 1'b1, 1'b0);
        step(1'b1, 30'd10, 1'b1, 1'b1, 1'b0);
        n_checks++;
        if (out_valid !== 1'b1 || out_acc !== 33'd28 || out_count !== 4'd4) begin
            n_fail++;
            $display("FAIL flush_block: valid=%b acc=%0d cnt=%0d, required 1/28/4",
                     out_valid, out_acc, out_count);
        end
        step(1'b0, 30'd0, 1'b1, 1'b1, 1'b0);
        step(1'b0, 30'd0, 1'b1, 1'b1, 1'b0);
        n_checks++;
        if (out_valid !== 1'b0 || out_acc !== 33'd28) begin
            n_fail++;
            $display("FAIL flush_empty: valid=%b acc=%0d, required 0/28", out_valid, out_acc);
        end
    endtask

    task automatic test_overflow();
        int pops;
        for (int i = 0; i < 24; i++) begin
            step(1'b1, 30'd1, 1'b0, 1'b0, 1'b0);
            if (i == 15 || i == 22) begin
                n_checks++;
                if (out_valid !== 1'b1 || out_acc !== 33'd8 || overflow !== 1'b0) begin
                    n_fail++;
                    $display("FAIL ovf_hold_%0d: valid=%b acc=%0d ovf=%b, required 1/8/0",
                             i, out_valid, out_acc, overflow);
                end
            end
        end
        n_checks++;
        if (overflow !== 1'b1 || drop_count !== 8'd1 || out_acc !== 33'd8) begin
            n_fail++;
            $display("FAIL ovf_drop: ovf=%b drop=%0d acc=%0d, required 1/1/8",
                     overflow, drop_count, out_acc);
        end
        pops = 0;
        for (int i = 0; i < 5; i++) begin
            if (out_valid === 1'b1) pops++;
            step(1'b0, 30'd0, 1'b0, 1'b1, 1'b0);
        end
        n_checks++;
        if (pops != 2 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_drain: pops=%0d valid=%b, required 2/0", pops, out_valid);
        end
    endtask

    task automatic test_full_pop_same_cycle();
        step(1'b0, 30'd0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) step(1'b1, 30'd1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b1, 30'd2, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) step(1'b1, 30'd3, 1'b0, 1'b0, 1'b0);
        step(1'b1, 30'd3, 1'b0, 1'b1, 1'b0);
        n_checks++;
        if (drop_count !== 8'd0 || overflow !== 1'b0 || out_valid !== 1'b1 || out_acc !== 33'd16) begin
            n_fail++;
            $display("FAIL full_pop: drop=%0d ovf=%b valid=%b acc=%0d, required 0/0/1/16",
                     drop_count, overflow, out_valid, out_acc);
        end
        step(1'b0, 30'd0, 1'b0, 1'b1, 1'b0);
        n_checks++;
        if (out_valid !== 1'b1 || out_acc !== 33'd24 || out_count !== 4'd8) begin
            n_fail++;
            $display("FAIL full_pop_order: valid=%b acc=%0d cnt=%0d, required 1/24/8",
                     out_valid, out_acc, out_count);
        end
        step(1'b0, 30'd0, 1'b0, 1'b1, 1'b0);
        n_checks++;
        if (out_valid !== 1'b0 || out_acc !== 33'd24) begin
            n_fail++;
            $display("FAIL full_pop_empty: valid=%b acc=%0d, required 0/24", out_valid, out_acc);
        end
    endtask

    task automatic test_reset_mid_block();
        for (int i = 0; i < 5; i++) step(1'b1, 30'd7, 1'b0, 1'b1, 1'b0);
        step(1'b1, 30'd7, 1'b1, 1'b1, 1'b1);
        n_checks++;
        if (out_valid !== 1'b0 || out_acc !== 33'd0 || out_count !== 4'd0 ||
            overflow !== 1'b0 || drop_count !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_mid: valid=%b acc=%0d cnt=%0d ovf=%b drop=%0d, required all zero",
                     out_valid, out_acc, out_count, overflow, drop_count);
        end
        for (int i = 0; i < 8; i++) step(1'b1, 30'd2, 1'b0, 1'b1, 1'b0);
        n_checks++;
        if (out_valid !== 1'b1 || out_acc !== 33'd16 || out_count !== 4'd8) begin
            n_fail++;
            $display("FAIL reset_fresh: valid=%b acc=%0d cnt=%0d, required 1/16/8",
                     out_valid, out_acc, out_count);
        end
        step(1'b0, 30'd0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_drop_saturation();
        step(1'b0, 30'd0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 8 * 259; i++) step(1'b1, 30'd1, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (drop_count !== 8'd255 || overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL drop_saturate: drop=%0d ovf=%b, required 255/1", drop_count, overflow);
        end
    endtask

    task automatic test_random();
        logic        v, f, r, rst;
        logic [29:0] s;
        int          phase;
        int          errs;
        step(1'b0, 30'd0, 1'b0, 1'b0, 1'b1);
        errs = 0;
        for (int i = 0; i < 4000; i++) begin
            phase = (i / 200) % 3;
            v   = ($urandom_range(3, 0) != 0);
            s   = ($urandom_range(7, 0) == 0) ? 30'h3FFFFFFF : 30'($urandom);
            f   = ($urandom_range(11, 0) == 0);
            r   = (phase == 0) ? ($urandom_range(9, 0) == 0) : ($urandom_range(2, 0) != 0);
            rst = ($urandom_range(699, 0) == 0);
            step(v, s, f, r, rst);
            n_checks++;
            if (out_valid !== e_valid || out_acc !== e_acc || out_count !== e_count ||
                overflow !== e_ovf || drop_count !== e_drop) begin
                n_fail++;
                errs++;
                if (errs <= 10)
                    $display("FAIL random_%0d: got v=%b acc=%h cnt=%0d ovf=%b drop=%0d, required v=%b acc=%h cnt=%0d ovf=%b drop=%0d",
                             i, out_valid, out_acc, out_count, overflow, drop_count,
                             e_valid, e_acc, e_count, e_ovf, e_drop);
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset = 1'b1; in_valid = 1'b0; in_sum = 30'd0; flush = 1'b0; out_ready = 1'b0;
        model_cycle(1'b0, 30'd0, 1'b0, 1'b0, 1'b1);
        test_reset();
        test_basic();
        test_max_no_wrap();
        test_flush();
        test_overflow();
        test_full_pop_same_cycle();
        test_reset_mid_block();
        test_drop_saturation();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
